// File: rtl/sw_uart_pkg.sv
// Shared constants and state encodings for the Smith-Waterman host-link UART.
package sw_uart_pkg;

    // Register map (byte addresses)
    localparam logic [4:0] ADDR_RX     = 5'd0;
    localparam logic [4:0] ADDR_TX     = 5'd4;
    localparam logic [4:0] ADDR_STATUS = 5'd8;

    // STATUS bit positions
    localparam int unsigned ST_RX_OK     = 7;
    localparam int unsigned ST_TX_OK     = 6;
    localparam int unsigned ST_FRAME_ERR = 2;
    localparam int unsigned ST_TX_DROP   = 1;
    localparam int unsigned ST_RX_OVR    = 0;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/sw_uart_slave_if.sv
// Avalon-MM register port between the SW wrapper master and the UART slave.
interface sw_uart_slave_if;

    logic [4:0]  avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata,
        output avm_readdata, avm_waitrequest
    );

endinterface

// File: rtl/sw_uart_rx.sv
// Serial receiver: input synchronizer plus start/data/stop framing FSM.
module sw_uart_rx
    import sw_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       avm_clk,
    input  logic       avm_rst,
    input  logic       uart_rxd,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int unsigned CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned HALF = CLKS_PER_BIT / 2;

    logic [1:0]    sync_r;
    logic          rxd_s;
    rx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    assign rxd_s = sync_r[1];

    // Two-flop synchronizer; resets to the idle line level
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) sync_r <= 2'b11;
        else         sync_r <= {sync_r[0], uart_rxd};
    end

    // Framing FSM: mid-bit sampling anchored on the half-bit start check
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (!rxd_s) state <= RX_START;
                end
                RX_START: begin
                    if (cnt == CW'(HALF - 1)) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rxd_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                        cnt     <= '0;
                        shift   <= {rxd_s, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= RX_STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (rxd_s) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shift;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sw_uart_slave.sv
// Avalon-MM UART slave: RX FIFO, TX holding register + shifter, register decode.
module sw_uart_slave
    import sw_uart_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned BAUD     = 115200,
    parameter int unsigned RX_DEPTH = 4
) (
    input  logic             avm_clk,
    input  logic             avm_rst,
    sw_uart_slave_if.slave   bus,
    input  logic             uart_rxd,
    output logic             uart_txd
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned AW = $clog2(RX_DEPTH);
    localparam int unsigned PW = AW + 1;

    logic          ack_r, req, acc_rd, acc_wr;
    logic          addr_rx, addr_tx, addr_st;
    logic          rx_byte_valid, rx_frame_err;
    logic [7:0]    rx_byte_data;
    logic [7:0]    fifo_mem [RX_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          fifo_empty, fifo_full, push, pop, rx_had_data;
    logic          frame_err_r, tx_drop_r, rx_ovr_r, st_clr;
    logic          hold_full, wr_tx, tx_take, tx_last;
    logic [7:0]    hold_data, tx_shift, status_c;
    tx_state_t     tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic          unused_wdata;

    assign unused_wdata = ^bus.avm_writedata[31:8];

    // One wait state per access; request with ack_r high is the completion cycle
    assign req                 = bus.avm_read | bus.avm_write;
    assign bus.avm_waitrequest = req & ~ack_r;
    assign acc_rd              = req & ack_r & bus.avm_read;
    assign acc_wr              = req & ack_r & bus.avm_write & ~bus.avm_read;
    assign addr_rx             = (bus.avm_address == ADDR_RX);
    assign addr_tx             = (bus.avm_address == ADDR_TX);
    assign addr_st             = (bus.avm_address == ADDR_STATUS);

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // Pop only if the captured read actually returned a byte
    assign pop        = acc_rd & addr_rx & rx_had_data;
    assign push       = rx_byte_valid & (~fifo_full | pop);
    assign st_clr     = acc_rd & addr_st;
    assign wr_tx      = acc_wr & addr_tx;
    assign tx_last    = (tx_cnt == CW'(CLKS_PER_BIT - 1));
    assign tx_take    = hold_full & ((tx_state == TX_IDLE) | ((tx_state == TX_STOP) & tx_last));

    // STATUS word assembly
    always_comb begin
        status_c               = '0;
        status_c[ST_RX_OK]     = ~fifo_empty;
        status_c[ST_TX_OK]     = ~hold_full;
        status_c[ST_FRAME_ERR] = frame_err_r;
        status_c[ST_TX_DROP]   = tx_drop_r;
        status_c[ST_RX_OVR]    = rx_ovr_r;
    end

    sw_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .avm_clk    (avm_clk),
        .avm_rst    (avm_rst),
        .uart_rxd   (uart_rxd),
        .byte_valid (rx_byte_valid),
        .byte_data  (rx_byte_data),
        .frame_err  (rx_frame_err)
    );

    // Access handshake and registered read data, captured in the wait-state cycle
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            ack_r            <= 1'b0;
            bus.avm_readdata <= '0;
            rx_had_data      <= 1'b0;
        end else begin
            ack_r            <= req & ~ack_r;
            bus.avm_readdata <= '0;
            if (bus.avm_read & ~ack_r) begin
                if (addr_rx) begin
                    bus.avm_readdata <= {24'h0, fifo_empty ? 8'h00 : fifo_mem[rd_ptr[AW-1:0]]};
                    rx_had_data      <= ~fifo_empty;
                end else if (addr_st) begin
                    bus.avm_readdata <= {24'h0, status_c};
                end
            end
        end
    end

    // RX FIFO pointers
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // RX FIFO storage
    always_ff @(posedge avm_clk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= rx_byte_data;
    end

    // Sticky error flags; a fresh event on the clearing edge still sets
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            frame_err_r <= 1'b0;
            tx_drop_r   <= 1'b0;
            rx_ovr_r    <= 1'b0;
        end else begin
            frame_err_r <= (frame_err_r & ~st_clr) | rx_frame_err;
            tx_drop_r   <= (tx_drop_r & ~st_clr) | (wr_tx & hold_full);
            rx_ovr_r    <= (rx_ovr_r & ~st_clr) | (rx_byte_valid & fifo_full & ~pop);
        end
    end

    // TX holding register
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else begin
            if (tx_take) hold_full <= 1'b0;
            if (wr_tx & ~hold_full) begin
                hold_full <= 1'b1;
                hold_data <= bus.avm_writedata[7:0];
            end
        end
    end

    // TX shifter FSM; the stop bit can chain straight into the next start bit
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            uart_txd <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx_cnt <= '0;
                    if (hold_full) begin
                        tx_state <= TX_START;
                        tx_shift <= hold_data;
                        uart_txd <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_last) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        tx_state <= TX_DATA;
                        uart_txd <= tx_shift[0];
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_last) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx_state <= TX_STOP;
                            uart_txd <= 1'b1;
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            uart_txd <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_last) begin
                        tx_cnt <= '0;
                        if (hold_full) begin
                            tx_state <= TX_START;
                            tx_shift <= hold_data;
                            uart_txd <= 1'b0;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sw_uart_slave.sv
// Bench for sw_uart_slave: scoreboarded bus reads, serial TX decoder, queue-based model.
module tb_sw_uart_slave;
    import sw_uart_pkg::*;

    localparam int unsigned CPB = 16;

    logic avm_clk  = 1'b0;
    logic avm_rst  = 1'b1;
    logic uart_rxd = 1'b1;
    logic uart_txd;

    sw_uart_slave_if bus ();

    sw_uart_slave #(.CLK_HZ(16), .BAUD(1), .RX_DEPTH(4)) dut (
        .avm_clk  (avm_clk),
        .avm_rst  (avm_rst),
        .bus      (bus),
        .uart_rxd (uart_rxd),
        .uart_txd (uart_txd)
    );

    always #5 avm_clk = ~avm_clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0]  mdl_rx [$];
    logic [7:0]  tx_exp [$];
    logic [31:0] sb_q   [$];
    string       sb_nm  [$];
    bit m_ovr = 0, m_ferr = 0, m_drop = 0, m_hold_full = 0;
    bit tx_mon_en = 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mdl_status();
        logic [31:0] s;
        s     = '0;
        s[7]  = (mdl_rx.size() != 0);
        s[6]  = !m_hold_full;
        s[2]  = m_ferr;
        s[1]  = m_drop;
        s[0]  = m_ovr;
        return s;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge avm_clk);
        #1;
    endtask

    // One bus access; a read pushes its expected data for the monitor
    task automatic access(input logic [4:0] a, input bit rd, input bit wr,
                          input logic [31:0] wd, input logic [31:0] exp, input string nm);
        int waits;
        bit done;
        if (rd) begin
            sb_q.push_back(exp);
            sb_nm.push_back(nm);
        end
        bus.avm_address   = a;
        bus.avm_read      = rd;
        bus.avm_write     = wr;
        bus.avm_writedata = wd;
        waits = 0;
        done  = 0;
        for (int i = 0; i < 8 && !done; i++) begin
            @(negedge avm_clk);
            if (!bus.avm_waitrequest) done = 1;
            else waits++;
        end
        check({nm, "_waitstates"}, 32'(waits), 32'd1);
        @(posedge avm_clk);
        #1;
        bus.avm_read  = 0;
        bus.avm_write = 0;
    endtask

    task automatic rd_status(input string nm);
        logic [31:0] e;
        e = mdl_status();
        m_ovr = 0; m_ferr = 0; m_drop = 0;
        access(ADDR_STATUS, 1, 0, 32'h0, e, nm);
    endtask

    task automatic rd_rx(input string nm);
        logic [31:0] e;
        e = '0;
        if (mdl_rx.size() != 0) e = {24'h0, mdl_rx.pop_front()};
        access(ADDR_RX, 1, 0, 32'h0, e, nm);
    endtask

    task automatic wr_tx(input logic [7:0] b, input string nm);
        logic [31:0] wd;
        wd = $urandom();
        wd[7:0] = b;
        if (m_hold_full) m_drop = 1;
        else begin
            m_hold_full = 1;
            tx_exp.push_back(b);
        end
        access(ADDR_TX, 0, 1, wd, 32'h0, nm);
    endtask

    // Drive one serial frame and update the model with its outcome
    task automatic send_frame(input logic [7:0] b, input bit stop);
        uart_rxd = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            idle(CPB);
        end
        uart_rxd = stop;
        idle(CPB);
        uart_rxd = 1'b1;
        idle(6);
        if (!stop)                   m_ferr = 1;
        else if (mdl_rx.size() < 4)  mdl_rx.push_back(b);
        else                         m_ovr = 1;
    endtask

    // Read monitor: compares every completed read against the scoreboard
    always @(negedge avm_clk) begin
        if (bus.avm_read && !bus.avm_waitrequest) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got 0x%08h expected none", bus.avm_readdata);
            end else begin
                check(sb_nm.pop_front(), bus.avm_readdata, sb_q.pop_front());
            end
        end
    end

    // Serial TX decoder: mid-bit sampling from the detected falling edge
    initial begin
        forever begin
            @(negedge avm_clk);
            if (tx_mon_en && uart_txd === 1'b0) begin : decode
                logic [7:0] got;
                repeat (CPB / 2) @(negedge avm_clk);
                check("tx_start_bit", 32'(uart_txd), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge avm_clk);
                    got[i] = uart_txd;
                end
                repeat (CPB) @(negedge avm_clk);
                check("tx_stop_bit", 32'(uart_txd), 32'd1);
                if (tx_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected_frame: got 0x%02h expected none", got);
                end else begin
                    check("tx_byte", {24'h0, got}, {24'h0, tx_exp.pop_front()});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b0, b1, b2;
        bus.avm_address   = '0;
        bus.avm_read      = 0;
        bus.avm_write     = 0;
        bus.avm_writedata = '0;

        // Reset values
        idle(3);
        @(negedge avm_clk);
        check("rst_waitrequest", 32'(bus.avm_waitrequest), 32'd0);
        check("rst_readdata", bus.avm_readdata, 32'h0);
        check("rst_txd", 32'(uart_txd), 32'd1);
        @(posedge avm_clk);
        #1 avm_rst = 0;
        idle(2);

        rd_status("status_after_reset");
        check("txd_idle", 32'(uart_txd), 32'd1);

        // Single known frame
        send_frame(8'hA5, 1);
        rd_status("status_rx_a5");
        rd_rx("rx_a5");
        rd_status("status_after_a5");

        // Random RX bytes
        for (int i = 0; i < 5; i++) begin
            send_frame(8'($urandom()), 1);
            rd_status("status_rx_rand");
            rd_rx("rx_rand");
        end
        rd_rx("rx_empty");

        // Decode corners: unmapped read, ignored write, read+write is a read
        access(5'd12, 1, 0, 32'h0, 32'h0, "rd_unmapped");
        access(ADDR_RX, 0, 1, 32'h0000_0077, 32'h0, "wr_rx_ignored");
        access(ADDR_TX, 1, 1, 32'h0000_0055, 32'h0, "rdwr_tx");
        idle(2);
        rd_status("status_after_decode");

        // TX of 0x3C with an immediate STATUS read
        wr_tx(8'h3C, "wr_3c");
        rd_status("status_tx_busy");
        m_hold_full = 0;
        idle(170);
        rd_status("status_tx_done");

        // Back-to-back frames and a dropped third byte
        b0 = 8'($urandom()); b1 = 8'($urandom()); b2 = 8'($urandom());
        wr_tx(b0, "wr_b0");
        idle(3);
        m_hold_full = 0;
        wr_tx(b1, "wr_b1");
        rd_status("status_hold_full");
        wr_tx(b2, "wr_b2_drop");
        rd_status("status_tx_drop");
        idle(200);
        m_hold_full = 0;
        rd_status("status_b1_taken");
        idle(200);

        // Overrun: five frames into a four-deep FIFO
        for (int i = 0; i < 5; i++) send_frame(8'($urandom()), 1);
        rd_status("status_overrun");
        for (int i = 0; i < 4; i++) rd_rx("rx_overrun_order");
        rd_status("status_overrun_cleared");

        // Framing error, then a short glitch, then a good frame
        send_frame(8'($urandom()), 0);
        rd_status("status_frame_err");
        rd_status("status_frame_err_cleared");
        uart_rxd = 1'b0;
        idle(5);
        uart_rxd = 1'b1;
        idle(40);
        rd_status("status_after_glitch");
        send_frame(8'($urandom()), 1);
        rd_rx("rx_after_glitch");

        // Reset in the middle of a TX frame
        tx_mon_en = 0;
        wr_tx(8'h00, "wr_before_reset");
        idle(40);
        @(negedge avm_clk);
        check("txd_mid_frame", 32'(uart_txd), 32'd0);
        @(posedge avm_clk);
        #1 avm_rst = 1;
        @(negedge avm_clk);
        check("txd_in_reset", 32'(uart_txd), 32'd1);
        tx_exp.delete();
        mdl_rx.delete();
        m_ovr = 0; m_ferr = 0; m_drop = 0; m_hold_full = 0;
        idle(2);
        avm_rst = 0;
        idle(2);
        rd_status("status_after_mid_reset");
        check("txd_after_reset", 32'(uart_txd), 32'd1);
        tx_mon_en = 1;

        idle(20);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        check("tx_frames_drained", 32'(tx_exp.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
